mem: RTL and testbench

Single-port, word-addressed on-chip RAM with a Wishbone slave interface. Sits on the system Wishbone bus as a general-purpose data store, for example frame or pattern storage for the LED pipeline. It serves one read or write per request with a registered, fixed single-cycle acknowledge.

---
 rtl/mem.sv | 67 ++++++
 tb/tb_mem.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem.sv
`default_nettype none
// ============================================================================
// Module      : mem
// Description : Single-port word-addressed RAM behind a Wishbone slave with a
//               registered single-cycle acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    input  logic                  wbs_write,
    output logic                  wbs_ack
);

    localparam int                c_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] c_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_WORDS-1];
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_ack;

    logic                  w_req;
    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_idx;

    // The ~ack term makes a held strobe accept at most every other cycle.
    assign w_req      = reset & wbs_cycle & wbs_strobe & ~r_ack;
    assign w_in_range = ({1'b0, wbs_address} < c_LIMIT);
    assign w_idx      = wbs_address[c_IDX_W-1:0];

    // Storage port kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_req && wbs_write && w_in_range) begin
            r_mem[w_idx] <= wbs_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (w_req && !wbs_write) begin
            r_readdata <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_req;
        end
    end

    assign wbs_readdata = r_readdata;
    assign wbs_ack      = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem
// Description : Randomised self-checking bench for mem against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem;

    localparam int c_AW = 16;
    localparam int c_DW = 32;
    localparam int c_MW = 1024;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [c_AW-1:0] wbs_address = '0;
    logic [c_DW-1:0] wbs_writedata = '0;
    logic [c_DW-1:0] wbs_readdata;
    logic            wbs_strobe = 1'b0;
    logic            wbs_cycle = 1'b0;
    logic            wbs_write = 1'b0;
    logic            wbs_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [c_DW-1:0] ref_mem [0:c_MW-1];
    logic [c_DW-1:0] ref_rdata = '0;

    mem #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .MEM_WORDS  (c_MW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .wbs_address   (wbs_address),
        .wbs_writedata (wbs_writedata),
        .wbs_readdata  (wbs_readdata),
        .wbs_strobe    (wbs_strobe),
        .wbs_cycle     (wbs_cycle),
        .wbs_write     (wbs_write),
        .wbs_ack       (wbs_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_DW-1:0] obs, input logic [c_DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_DW-1:0] model_read(input int a);
        return (a < c_MW) ? ref_mem[a] : '0;
    endfunction

    // One Wishbone transaction; hold keeps strobe up until ack is seen.
    task automatic wb_op(input logic we, input int a, input logic [c_DW-1:0] d, input bit hold);
        wbs_cycle     = 1'b1;
        wbs_strobe    = 1'b1;
        wbs_write     = we;
        wbs_address   = a[c_AW-1:0];
        wbs_writedata = d;
        @(posedge clk); #1;
        if (we) begin
            if (a < c_MW) ref_mem[a] = d;
        end else begin
            ref_rdata = model_read(a);
        end
        check("ack_pulse", {31'b0, wbs_ack}, 32'd1);
        check(we ? "rdata_hold" : "rdata", wbs_readdata, ref_rdata);
        if (!hold) begin
            wbs_strobe    = 1'b0;
            wbs_cycle     = 1'b0;
            wbs_address   = c_AW'($urandom);
            wbs_writedata = $urandom;
        end
        @(posedge clk); #1;
        check("ack_single", {31'b0, wbs_ack}, 32'd0);
        check("rdata_after", wbs_readdata, ref_rdata);
        wbs_strobe = 1'b0;
        wbs_cycle  = 1'b0;
    endtask

    task automatic reset_phase(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            wbs_cycle     = 1'b1;
            wbs_strobe    = ~wbs_strobe;
            wbs_write     = 1'($urandom);
            wbs_address   = c_AW'($urandom_range(0, c_MW - 1));
            wbs_writedata = $urandom;
            @(posedge clk); #1;
            check("rst_ack", {31'b0, wbs_ack}, 32'd0);
            check("rst_rdata", wbs_readdata, 32'd0);
        end
        wbs_cycle  = 1'b0;
        wbs_strobe = 1'b0;
        ref_rdata  = '0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        reset_phase(100);

        for (int a = 0; a < c_MW; a++) wb_op(1'b1, a, 32'hFFFF_FFFF - a, 1'b0);
        for (int a = 0; a < c_MW; a++) wb_op(1'b0, a, '0, 1'b0);

        wb_op(1'b1, 3, 32'hDEAD_BEEF, 1'b1);
        wb_op(1'b0, 3, '0, 1'b1);

        wb_op(1'b1, 1024, 32'h1234_5678, 1'b0);
        wb_op(1'b0, 1024, '0, 1'b0);
        wb_op(1'b0, 0, '0, 1'b0);
        wb_op(1'b0, 16'hFFFF, '0, 1'b0);

        wb_op(1'b1, 7, 32'hA5A5_A5A5, 1'b0);
        wb_op(1'b0, 7, '0, 1'b0);

        // Reset lands on the edge that would retire the read's ack.
        wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b0; wbs_address = 16'd10;
        @(posedge clk); #1;
        check("midrst_ack_before", {31'b0, wbs_ack}, 32'd1);
        check("midrst_rdata_before", wbs_readdata, 32'hFFFF_FFF5);
        reset = 1'b0; wbs_strobe = 1'b0; wbs_cycle = 1'b0;
        @(posedge clk); #1;
        check("midrst_ack", {31'b0, wbs_ack}, 32'd0);
        check("midrst_rdata", wbs_readdata, 32'd0);
        ref_rdata = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        wb_op(1'b0, 10, '0, 1'b0);

        // A write sampled just before reset is still committed.
        wbs_cycle = 1'b1; wbs_strobe = 1'b1; wbs_write = 1'b1;
        wbs_address = 16'd20; wbs_writedata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        ref_mem[20] = 32'h0BAD_F00D;
        reset = 1'b0; wbs_strobe = 1'b0; wbs_cycle = 1'b0;
        @(posedge clk); #1;
        check("prerst_ack", {31'b0, wbs_ack}, 32'd0);
        ref_rdata = '0;
        reset = 1'b1;
        wb_op(1'b0, 20, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(c_MW, 65535))
                                            : int'($urandom_range(0, c_MW - 1));
            wb_op(1'($urandom), a, $urandom, 1'($urandom));
        end

        reset_phase(50);
        for (int a = 0; a < c_MW; a++) wb_op(1'b0, a, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
